vram_arbiter: RTL and testbench

Arbitrates the single-port, synchronous-read video RAM between two requesters: the i8080 memory bus (read/write) and the video scanout fetcher (read-only). Video has fixed priority, with a bounded-wait rule so the CPU is never starved. The block sits between `invaders`' CPU bus decode and `ram`, and serialises one RAM access at a time through a four-state sequencer.

---
 rtl/vram_arbiter.sv | 88 ++++++++
 tb/tb_vram_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: serialises CPU and video access to a single-port synchronous video RAM, video first with bounded CPU wait
module vram_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ack,
  input  logic              i_vid_req,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic [DATA_W-1:0] o_vid_rdata,
  output logic              o_vid_ack,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;
  state_t            r_state, w_next;
  logic              r_owner;
  logic              r_wr;
  logic [3:0]        r_wait_cnt;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_vid_rdata;
  logic              w_idle;
  logic              w_cpu_win;
  logic              w_vid_win;
  logic              w_sat;
  always_comb begin
    w_idle    = r_state == IDLE;
    w_sat     = r_wait_cnt == 4'(MAX_WAIT);
    w_cpu_win = i_cpu_req && (w_sat || !i_vid_req);
    w_vid_win = i_vid_req && !w_cpu_win;
  end
  always_comb begin
    w_next = w_idle ? ((i_cpu_req || i_vid_req) ? ACCESS : IDLE) :
             (r_state == ACCESS) ? WAIT :
             (r_state == WAIT) ? ACK : IDLE;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_owner     <= 1'b0;
      r_wr        <= 1'b0;
      r_wait_cnt  <= '0;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_cpu_rdata <= '0;
      r_vid_rdata <= '0;
    end else begin
      r_ram_we <= w_idle && w_cpu_win && i_cpu_we;
      if (w_idle) begin
        r_wait_cnt <= (w_cpu_win || !i_cpu_req) ? 4'd0 :
                      (w_vid_win && !w_sat) ? r_wait_cnt + 4'd1 : r_wait_cnt;
        if (w_cpu_win || w_vid_win) begin
          r_owner     <= w_cpu_win;
          r_wr        <= w_cpu_win && i_cpu_we;
          r_ram_addr  <= w_cpu_win ? i_cpu_addr : i_vid_addr;
          r_ram_wdata <= w_cpu_win ? i_cpu_wdata : r_ram_wdata;
        end
      end
      if (r_state == WAIT) begin
        r_cpu_rdata <= (r_owner && !r_wr) ? i_ram_rdata : r_cpu_rdata;
        r_vid_rdata <= !r_owner ? i_ram_rdata : r_vid_rdata;
      end
    end
  always_comb begin
    o_cpu_ack   = r_state == ACK && r_owner;
    o_vid_ack   = r_state == ACK && !r_owner;
    o_cpu_rdata = r_cpu_rdata;
    o_vid_rdata = r_vid_rdata;
    o_ram_addr  = r_ram_addr;
    o_ram_we    = r_ram_we;
    o_ram_wdata = r_ram_wdata;
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed self-checking bench for vram_arbiter with a synchronous-read RAM model
module tb_vram_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        vid_req = 1'b0;
  logic [12:0] vid_addr = '0;
  logic [7:0]  vid_rdata;
  logic        vid_ack;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic [7:0]  mem [0:8191];
  int          checks = 0;
  int          errors = 0;
  vram_arbiter #(.ADDR_W(13), .DATA_W(8), .MAX_WAIT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_ack(cpu_ack),
    .i_vid_req(vid_req), .i_vid_addr(vid_addr), .o_vid_rdata(vid_rdata), .o_vid_ack(vid_ack),
    .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end
  task automatic test_reset();
    cpu_req = 1'b1;
    vid_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %0h want 0", ram_we); end
    checks++; if (cpu_ack !== 1'b0 || vid_ack !== 1'b0) begin errors++; $display("FAIL reset_acks got %0b%0b want 00", cpu_ack, vid_ack); end
    checks++; if (ram_addr !== 13'h0) begin errors++; $display("FAIL reset_ram_addr got %0h want 0", ram_addr); end
    checks++; if (ram_wdata !== 8'h0) begin errors++; $display("FAIL reset_ram_wdata got %0h want 0", ram_wdata); end
    checks++; if (cpu_rdata !== 8'h0 || vid_rdata !== 8'h0) begin errors++; $display("FAIL reset_rdata got %0h/%0h want 0/0", cpu_rdata, vid_rdata); end
    checks++; if (dut.r_wait_cnt !== 4'd0) begin errors++; $display("FAIL reset_wait_cnt got %0d want 0", dut.r_wait_cnt); end
    cpu_req = 1'b0;
    vid_req = 1'b0;
    rst = 1'b0;
  endtask
  task automatic test_cpu_write_read();
    int lat, we_cycles, bad_addr;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h07FE; cpu_wdata = 8'h5A;
    lat = 0; we_cycles = 0; bad_addr = 0;
    while (cpu_ack !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
      if (ram_we === 1'b1) begin
        we_cycles++;
        if (ram_addr !== 13'h07FE || lat != 1) bad_addr++;
      end
    end
    cpu_req = 1'b0;
    checks++; if (lat != 3) begin errors++; $display("FAIL wr_latency got %0d want 3", lat); end
    checks++; if (we_cycles != 1 || bad_addr != 0) begin errors++; $display("FAIL wr_we_pulse got %0d cycles (%0d misplaced) want 1 (0)", we_cycles, bad_addr); end
    checks++; if (mem[13'h07FE] !== 8'h5A) begin errors++; $display("FAIL wr_mem got %0h want 5a", mem[13'h07FE]); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL wr_no_rdata got %0h want 0", cpu_rdata); end
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0;
    lat = 0; we_cycles = 0;
    while (cpu_ack !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
      if (ram_we === 1'b1) we_cycles++;
    end
    cpu_req = 1'b0;
    checks++; if (lat != 3) begin errors++; $display("FAIL rd_latency got %0d want 3", lat); end
    checks++; if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL rd_data got %0h want 5a", cpu_rdata); end
    checks++; if (we_cycles != 0) begin errors++; $display("FAIL rd_we got %0d cycles want 0", we_cycles); end
    @(negedge clk);
    checks++; if (cpu_rdata !== 8'h5A || cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_hold got data %0h ack %0b want 5a 0", cpu_rdata, cpu_ack); end
  endtask
  task automatic test_simultaneous();
    int tv, tc;
    logic [7:0] vd, cd;
    mem[13'h0400] = 8'h11;
    mem[13'h0010] = 8'h22;
    tv = 0; tc = 0; vd = '0; cd = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
    vid_req = 1'b1; vid_addr = 13'h0400;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (vid_ack === 1'b1) begin tv = c; vd = vid_rdata; vid_req = 1'b0; end
      if (cpu_ack === 1'b1) begin tc = c; cd = cpu_rdata; cpu_req = 1'b0; end
    end
    checks++; if (tv != 3) begin errors++; $display("FAIL sim_vid_ack_cycle got %0d want 3", tv); end
    checks++; if (tc != 7) begin errors++; $display("FAIL sim_cpu_ack_cycle got %0d want 7", tc); end
    checks++; if (vd !== 8'h11) begin errors++; $display("FAIL sim_vid_data got %0h want 11", vd); end
    checks++; if (cd !== 8'h22) begin errors++; $display("FAIL sim_cpu_data got %0h want 22", cd); end
  endtask
  task automatic test_starvation();
    int nv, tc, tv, cnt16;
    mem[13'h0100] = 8'h77;
    mem[13'h0200] = 8'h3C;
    nv = 0; tc = 0; tv = 0; cnt16 = -1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0200;
    vid_req = 1'b1; vid_addr = 13'h0100;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 16) cnt16 = int'(dut.r_wait_cnt);
      if (cpu_ack === 1'b1) begin tc = c; cpu_req = 1'b0; end
      if (vid_ack === 1'b1) begin
        if (tc == 0) nv++;
        else if (tv == 0) begin tv = c; vid_req = 1'b0; end
      end
    end
    checks++; if (nv != 4) begin errors++; $display("FAIL starve_vid_acks got %0d want 4", nv); end
    checks++; if (tc != 19) begin errors++; $display("FAIL starve_cpu_ack_cycle got %0d want 19", tc); end
    checks++; if (tv != 23) begin errors++; $display("FAIL starve_vid_resume_cycle got %0d want 23", tv); end
    checks++; if (cnt16 != 4) begin errors++; $display("FAIL starve_wait_cnt got %0d want 4", cnt16); end
    checks++; if (cpu_rdata !== 8'h3C || vid_rdata !== 8'h77) begin errors++; $display("FAIL starve_data got %0h/%0h want 3c/77", cpu_rdata, vid_rdata); end
  endtask
  task automatic test_reset_mid_write();
    int acks, lat;
    mem[13'h0333] = 8'h00;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0333; cpu_wdata = 8'hA5;
    @(negedge clk);
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL rmw_we_before got %0b want 1", ram_we); end
    #1 rst = 1'b1;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rmw_we_async got %0b want 0", ram_we); end
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) acks++;
    end
    checks++; if (acks != 0 || mem[13'h0333] !== 8'h00) begin errors++; $display("FAIL rmw_abandon got %0d acks mem %0h want 0 acks mem 0", acks, mem[13'h0333]); end
    rst = 1'b0;
    lat = 0;
    while (cpu_ack !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    cpu_req = 1'b0;
    checks++; if (lat != 3) begin errors++; $display("FAIL rmw_retry_latency got %0d want 3", lat); end
    checks++; if (mem[13'h0333] !== 8'hA5) begin errors++; $display("FAIL rmw_retry_mem got %0h want a5", mem[13'h0333]); end
  endtask
  task automatic test_idle();
    int acks, wes;
    acks = 0; wes = 0;
    @(negedge clk);
    repeat (20) begin
      @(negedge clk);
      if (cpu_ack !== 1'b0 || vid_ack !== 1'b0) acks++;
      if (ram_we !== 1'b0) wes++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL idle_acks got %0d want 0", acks); end
    checks++; if (wes != 0) begin errors++; $display("FAIL idle_we got %0d want 0", wes); end
    checks++; if (dut.r_wait_cnt !== 4'd0) begin errors++; $display("FAIL idle_wait_cnt got %0d want 0", dut.r_wait_cnt); end
  endtask
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    test_reset();
    test_cpu_write_read();
    test_simultaneous();
    test_starvation();
    test_reset_mid_write();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
